vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates VGA raster timing for the display pipeline: pixel clock-enable, horizontal/vertical sync, display-active flag and pixel coordinates. It sits directly upstream of the per-pixel colour stages. Its `display_en` drives their `enable` input, and `x` drives their 10-bit coordinate input. Default parameters give 640x480 @ 60 Hz from a 50 MHz `clk` (25 MHz pixel rate).

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `PIX_DIV`, 2: `clk` cycles per pixel (1..16)
- `SYNC_ACTIVE_HIGH`, 0: sync pulse polarity; 0 means pulses are low
- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous assert, active-low
- `pix_ce` out 1: one-`clk` pulse each pixel slot
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `display_en` out 1: current pixel is visible
- `x` out 10: horizontal pixel coordinate
- `y` out 10: vertical line coordinate
- `line_start` out 1: one-`clk` strobe at h = 0
- `frame_start` out 1: one-`clk` strobe at h = 0, v = 0

## Operation
- Totals: H_TOTAL = sum of the H_* parameters (800), V_TOTAL = sum of the V_* parameters (525). Both must be ≤ 1024; elaboration fails otherwise.
- Divider: counts 0..PIX_DIV-1 and wraps. `pix_ce` = 1 when the divider equals PIX_DIV-1. With PIX_DIV = 1, `pix_ce` is constantly 1 after reset.
- Position counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1) advance only on `pix_ce` edges:
  - `h` wraps from H_TOTAL-1 to 0 and increments `v` on the same edge.
  - `v` wraps from V_TOTAL-1 to 0.
- Per-axis FSM: ACTIVE → FRONT_PORCH → SYNC → BACK_PORCH → ACTIVE.
  - Transitions occur on the `pix_ce` edge where the segment counter reaches its length minus 1.
  - The vertical FSM steps only on horizontal wrap.
  - The FSM state is the sole source for the sync and enable decodes.
- Output decode, all outputs registered and loaded on `pix_ce` edges from the current (h, v) before that position advances:
  - `display_en` = (H ACTIVE and V ACTIVE)
  - `hsync` = H SYNC state, XOR inverted when SYNC_ACTIVE_HIGH = 0
  - `vsync` = V SYNC state, same polarity rule
  - `x` = h when `display_en`, else 0
  - `y` = v when `display_en`, else 0
- Strobes:
  - `line_start` is high for exactly the one `clk` cycle following the edge that loads h = 0.
  - `frame_start` is the same, additionally requiring v = 0.
  - Both are low in all other cycles.
- Sync ranges with defaults: hsync active for h 656..751, vsync active for v 490..491.

## Timing
- Reset values while `rst_n` = 0: divider 0, h = 0, v = 0, both FSMs ACTIVE, `pix_ce` 0, `display_en` 0, `x` 0, `y` 0, `line_start` 0, `frame_start` 0. `hsync`/`vsync` sit at their inactive level (1 when SYNC_ACTIVE_HIGH = 0).
- Reset assertion takes effect immediately, without a clock. Deassertion is sampled on `clk`.
- First `pix_ce` = 1 is in the PIX_DIV-th `clk` cycle after deassertion.
  - On that edge the outputs load position (0,0): `display_en` = 1, `x` = 0, `y` = 0.
  - The position moves to (1,0) on the same edge.
  - `frame_start` and `line_start` pulse in the following cycle.
- Outputs are constant across each pixel slot of PIX_DIV clks. All outputs change together on the same edge, with no skew between `x`, `display_en` and the syncs.
- Line period: H_TOTAL·PIX_DIV clks (1600). Frame period: H_TOTAL·V_TOTAL·PIX_DIV clks (840000).
- Reset mid-frame: all state returns to its reset value. The restart sequence is then identical to power-up.
- The last visible pixel (h = 639) and a wrap occurring on the same edge are both covered by the decode rules. `display_en` falls on the edge that loads h = 640.

## Test plan
- Reset values: hold `rst_n` = 0 for 10 clks with `clk` running → `hsync` = `vsync` = 1, all other outputs 0. Assert `rst_n` low asynchronously mid-cycle → outputs return to reset values before the next edge.
- First frame start: release reset → `pix_ce` first high in cycle 2, `display_en` = 1 with `x` = 0, `frame_start` high for exactly 1 clk. `x` = 639 occurs 1278 clks later, then `display_en` = 0 with `x` = 0 on the next pixel.
- Hsync: measure edges → hsync falls at h = 656 (1312 clks after line start) and stays low for 192 clks. Consecutive `line_start` pulses are 1600 clks apart.
- Vsync and frame: run two full frames → `vsync` low for exactly 3200 clks starting at v = 490, `frame_start` period 840000 clks, `y` reaches 479 and never exceeds it.
- Parameter variant PIX_DIV = 1, SYNC_ACTIVE_HIGH = 1 → `pix_ce` constantly 1, sync pulses high, line period 800 clks.
- Mid-frame reset: pulse `rst_n` low at v = 200, h = 300 → after release, the sequence matches the power-up sequence cycle-for-cycle.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and the per-pixel colour stages.
// The generator drives everything through the master modport.
interface vga_timing_if;
   logic       pix_ce;
   logic       hsync;
   logic       vsync;
   logic       display_en;
   logic [9:0] x;
   logic [9:0] y;
   logic       line_start;
   logic       frame_start;

   modport master (
      output pix_ce, hsync, vsync, display_en, x, y, line_start, frame_start
   );

   modport slave (
      input  pix_ce, hsync, vsync, display_en, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock-enable, per-axis porch/sync FSMs
// and registered sync, enable, coordinate and strobe outputs.
module vga_timing_gen #(
   parameter int H_ACTIVE         = 640,
   parameter int H_FP             = 16,
   parameter int H_SYNC           = 96,
   parameter int H_BP             = 48,
   parameter int V_ACTIVE         = 480,
   parameter int V_FP             = 10,
   parameter int V_SYNC           = 2,
   parameter int V_BP             = 33,
   parameter int PIX_DIV          = 2,
   parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_timing_if.master o_vga
);
   localparam int         H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int         V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [3:0] DIV_LAST  = 4'(PIX_DIV - 1);
   localparam logic       SYNC_IDLE = !SYNC_ACTIVE_HIGH;

   if (H_TOTAL > 1024) begin : g_h_total_check
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
   end
   if (V_TOTAL > 1024) begin : g_v_total_check
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
   end
   if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_pix_div_check
      $error("vga_timing_gen: PIX_DIV must be 1..16");
   end

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FRONT  = 2'd1,
      ST_SYNC   = 2'd2,
      ST_BACK   = 2'd3
   } seg_t;

   function automatic logic [9:0] h_seg_last(input seg_t s);
      case (s)
         ST_ACTIVE: h_seg_last = 10'(H_ACTIVE - 1);
         ST_FRONT:  h_seg_last = 10'(H_FP - 1);
         ST_SYNC:   h_seg_last = 10'(H_SYNC - 1);
         default:   h_seg_last = 10'(H_BP - 1);
      endcase
   endfunction

   function automatic logic [9:0] v_seg_last(input seg_t s);
      case (s)
         ST_ACTIVE: v_seg_last = 10'(V_ACTIVE - 1);
         ST_FRONT:  v_seg_last = 10'(V_FP - 1);
         ST_SYNC:   v_seg_last = 10'(V_SYNC - 1);
         default:   v_seg_last = 10'(V_BP - 1);
      endcase
   endfunction

   logic [3:0] r_div;
   logic       r_pix_ce;
   logic [9:0] r_h;
   logic [9:0] r_v;
   logic [9:0] r_h_seg;
   logic [9:0] r_v_seg;
   seg_t       r_h_state;
   seg_t       r_v_state;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_display_en;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic       r_line_start;
   logic       r_frame_start;

   logic w_h_wrap;
   logic w_h_seg_done;
   logic w_v_seg_done;
   logic w_visible;

   assign w_h_wrap     = (r_h == H_LAST);
   assign w_h_seg_done = (r_h_seg == h_seg_last(r_h_state));
   assign w_v_seg_done = (r_v_seg == v_seg_last(r_v_state));
   assign w_visible    = (r_h_state == ST_ACTIVE) && (r_v_state == ST_ACTIVE);

   // r_pix_ce trails the divider by one clk so it is 0 in reset even when PIX_DIV = 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div         <= '0;
         r_pix_ce      <= 1'b0;
         r_h           <= '0;
         r_v           <= '0;
         r_h_seg       <= '0;
         r_v_seg       <= '0;
         r_h_state     <= ST_ACTIVE;
         r_v_state     <= ST_ACTIVE;
         r_hsync       <= SYNC_IDLE;
         r_vsync       <= SYNC_IDLE;
         r_display_en  <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_div         <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
         r_pix_ce      <= (r_div == DIV_LAST);
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;

         if (r_pix_ce) begin
            // Outputs reflect the position before it advances on this same edge.
            r_display_en  <= w_visible;
            r_hsync       <= (r_h_state == ST_SYNC) ? !SYNC_IDLE : SYNC_IDLE;
            r_vsync       <= (r_v_state == ST_SYNC) ? !SYNC_IDLE : SYNC_IDLE;
            r_x           <= w_visible ? r_h : 10'd0;
            r_y           <= w_visible ? r_v : 10'd0;
            r_line_start  <= (r_h == 10'd0);
            r_frame_start <= (r_h == 10'd0) && (r_v == 10'd0);

            r_h <= w_h_wrap ? 10'd0 : r_h + 10'd1;
            if (w_h_seg_done) begin
               r_h_seg   <= '0;
               r_h_state <= seg_t'(r_h_state + 2'd1);
            end else begin
               r_h_seg   <= r_h_seg + 10'd1;
            end

            if (w_h_wrap) begin
               r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
               if (w_v_seg_done) begin
                  r_v_seg   <= '0;
                  r_v_state <= seg_t'(r_v_state + 2'd1);
               end else begin
                  r_v_seg   <= r_v_seg + 10'd1;
               end
            end
         end
      end
   end

   assign o_vga.pix_ce      = r_pix_ce;
   assign o_vga.hsync       = r_hsync;
   assign o_vga.vsync       = r_vsync;
   assign o_vga.display_en  = r_display_en;
   assign o_vga.x           = r_x;
   assign o_vga.y           = r_y;
   assign o_vga.line_start  = r_line_start;
   assign o_vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small geometry, PIX_DIV=1 active-high, defaults)
// checked every cycle against an arithmetic raster model, plus literal timing points.
module tb_vga_timing_gen;
   localparam int SA_HA = 16, SA_HFP = 3, SA_HS = 4, SA_HBP = 5;
   localparam int SA_VA = 6,  SA_VFP = 2, SA_VS = 2, SA_VBP = 3;

   typedef struct packed {
      logic       pix_ce;
      logic       hsync;
      logic       vsync;
      logic       de;
      logic [9:0] x;
      logic [9:0] y;
      logic       ls;
      logic       fs;
   } exp_t;

   logic   clk;
   logic   rst_n;
   longint t;
   bit     lit_en;
   int     errs;
   int     checks;

   vga_timing_if if_a ();
   vga_timing_if if_b ();
   vga_timing_if if_d ();

   vga_timing_gen #(
      .H_ACTIVE(SA_HA), .H_FP(SA_HFP), .H_SYNC(SA_HS), .H_BP(SA_HBP),
      .V_ACTIVE(SA_VA), .V_FP(SA_VFP), .V_SYNC(SA_VS), .V_BP(SA_VBP),
      .PIX_DIV(3), .SYNC_ACTIVE_HIGH(1'b0)
   ) dut_a (.clk(clk), .rst_n(rst_n), .o_vga(if_a));

   vga_timing_gen #(
      .H_ACTIVE(SA_HA), .H_FP(SA_HFP), .H_SYNC(SA_HS), .H_BP(SA_HBP),
      .V_ACTIVE(SA_VA), .V_FP(SA_VFP), .V_SYNC(SA_VS), .V_BP(SA_VBP),
      .PIX_DIV(1), .SYNC_ACTIVE_HIGH(1'b1)
   ) dut_b (.clk(clk), .rst_n(rst_n), .o_vga(if_b));

   vga_timing_gen dut_d (.clk(clk), .rst_n(rst_n), .o_vga(if_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count of clk edges since reset release; the model is a pure function of it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) t <= 0;
      else        t <= t + 1;
   end

   function automatic exp_t model(input longint tt, input int d,
                                  input int ha, input int hfp, input int hs, input int hbp,
                                  input int va, input int vfp, input int vs, input int vbp,
                                  input bit sah);
      exp_t   e;
      longint n, p;
      int     h, v, ht, vt;
      bit     vis;
      ht       = ha + hfp + hs + hbp;
      vt       = va + vfp + vs + vbp;
      e.pix_ce = (tt >= 1) && (tt % d == 0);
      e.hsync  = !sah;
      e.vsync  = !sah;
      e.de     = 1'b0;
      e.x      = '0;
      e.y      = '0;
      e.ls     = 1'b0;
      e.fs     = 1'b0;
      n = (tt >= d + 1) ? (tt - 1) / d : 0;
      if (n > 0) begin
         p   = n - 1;
         h   = int'(p % ht);
         v   = int'((p / ht) % vt);
         vis = (h < ha) && (v < va);
         e.de    = vis;
         e.x     = vis ? 10'(h) : 10'd0;
         e.y     = vis ? 10'(v) : 10'd0;
         e.hsync = (h >= ha + hfp && h < ha + hfp + hs) ? sah : !sah;
         e.vsync = (v >= va + vfp && v < va + vfp + vs) ? sah : !sah;
         if ((tt - 1) % d == 0) begin
            e.ls = (h == 0);
            e.fs = (h == 0) && (v == 0);
         end
      end
      return e;
   endfunction

   task automatic cmp(input string name, input exp_t got, input exp_t req);
      checks++;
      if (got !== req) begin
         errs++;
         if (errs <= 40)
            $display("FAIL %s t=%0d got pce=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b required pce=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                     name, t, got.pix_ce, got.hsync, got.vsync, got.de, got.x, got.y, got.ls, got.fs,
                     req.pix_ce, req.hsync, req.vsync, req.de, req.x, req.y, req.ls, req.fs);
      end
   endtask

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errs++;
         $display("FAIL %s t=%0d got %0d required %0d", name, t, got, req);
      end
   endtask

   always @(negedge clk) begin
      cmp("model_a", {if_a.pix_ce, if_a.hsync, if_a.vsync, if_a.display_en, if_a.x, if_a.y,
                      if_a.line_start, if_a.frame_start},
          model(t, 3, SA_HA, SA_HFP, SA_HS, SA_HBP, SA_VA, SA_VFP, SA_VS, SA_VBP, 1'b0));
      cmp("model_b", {if_b.pix_ce, if_b.hsync, if_b.vsync, if_b.display_en, if_b.x, if_b.y,
                      if_b.line_start, if_b.frame_start},
          model(t, 1, SA_HA, SA_HFP, SA_HS, SA_HBP, SA_VA, SA_VFP, SA_VS, SA_VBP, 1'b1));
      cmp("model_d", {if_d.pix_ce, if_d.hsync, if_d.vsync, if_d.display_en, if_d.x, if_d.y,
                      if_d.line_start, if_d.frame_start},
          model(t, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      if (lit_en) begin
         case (t)
            0:    begin chk("d_rst_hsync", int'(if_d.hsync), 1); chk("b_rst_hsync", int'(if_b.hsync), 0); end
            1:    begin chk("d_pce_t1", int'(if_d.pix_ce), 0); chk("b_pce_t1", int'(if_b.pix_ce), 1); end
            2:    begin chk("d_pce_t2", int'(if_d.pix_ce), 1); chk("d_de_t2", int'(if_d.display_en), 0);
                        chk("a_pce_t2", int'(if_a.pix_ce), 0); end
            3:    begin chk("d_de_t3", int'(if_d.display_en), 1); chk("d_x_t3", int'(if_d.x), 0);
                        chk("d_fs_t3", int'(if_d.frame_start), 1); chk("d_ls_t3", int'(if_d.line_start), 1);
                        chk("a_pce_t3", int'(if_a.pix_ce), 1); end
            4:    begin chk("d_fs_t4", int'(if_d.frame_start), 0); chk("a_fs_t4", int'(if_a.frame_start), 1); end
            20:   chk("b_hsync_t20", int'(if_b.hsync), 0);
            21:   chk("b_hsync_t21", int'(if_b.hsync), 1);
            29:   chk("b_ls_t29", int'(if_b.line_start), 0);
            30:   chk("b_ls_t30", int'(if_b.line_start), 1);
            1281: chk("d_x639", int'(if_d.x), 639);
            1283: begin chk("d_de_h640", int'(if_d.display_en), 0); chk("d_x_h640", int'(if_d.x), 0); end
            1314: chk("d_hsync_pre", int'(if_d.hsync), 1);
            1315: chk("d_hsync_fall", int'(if_d.hsync), 0);
            1506: chk("d_hsync_last", int'(if_d.hsync), 0);
            1507: chk("d_hsync_rise", int'(if_d.hsync), 1);
            1603: chk("d_ls_line1", int'(if_d.line_start), 1);
            default: ;
         endcase
      end
   end

   initial begin
      errs   = 0;
      checks = 0;
      lit_en = 1'b1;
      rst_n  = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      repeat (3000) @(negedge clk);
      lit_en = 1'b0;
      for (int r = 0; r < 4; r++) begin
         @(posedge clk);
         #2 rst_n = 1'b0;
         repeat ($urandom_range(1, 4)) @(negedge clk);
         rst_n = 1'b1;
         repeat ($urandom_range(300, 2500)) @(negedge clk);
      end
      // Final mid-frame reset: the restart must reproduce the power-up literal points.
      @(posedge clk);
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      lit_en = 1'b1;
      rst_n  = 1'b1;
      repeat (1700) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
